// File: rtl/mtimer_pkg.sv
// rtl/mtimer_pkg.sv - shared constants for the multi-channel machine timer
//
// Holds the word offsets of the register window, the CTRL field positions
// and the byte-lane masks selected by the 3-bit write_sections bus.

package mtimer_pkg;

  // Word offsets inside the register window
  localparam int unsigned OFF_MTIME_LO   = 0;
  localparam int unsigned OFF_MTIME_HI   = 1;
  localparam int unsigned OFF_CTRL       = 2;
  localparam int unsigned OFF_IRQ_STATUS = 3;
  localparam int unsigned OFF_CMP_BASE   = 4;

  // CTRL field positions
  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_DIV_LSB    = 8;

  // Lane masks: bit0 -> [7:0], bit1 -> [15:8], bit2 -> [31:16]
  localparam logic [31:0] LANE0_MASK = 32'h0000_00FF;
  localparam logic [31:0] LANE1_MASK = 32'h0000_FF00;
  localparam logic [31:0] LANE2_MASK = 32'hFFFF_0000;

  function automatic logic [31:0] lane_mask(input logic [2:0] sections);
    logic [31:0] m;
    m = 32'h0000_0000;
    if (sections[0]) m = m | LANE0_MASK;
    if (sections[1]) m = m | LANE1_MASK;
    if (sections[2]) m = m | LANE2_MASK;
    return m;
  endfunction

endpackage

// File: rtl/lane_write32.sv
// rtl/lane_write32.sv - merge enabled write lanes into a 32-bit word
//
// Ports:
//   old_word        current register contents
//   write_value     lane-shifted write data from the core
//   write_sections  lane enables (bit0 [7:0], bit1 [15:8], bit2 [31:16])
//   new_word        old_word with the enabled lanes replaced

import mtimer_pkg::*;

module lane_write32 (
  input  logic [31:0] old_word,
  input  logic [31:0] write_value,
  input  logic [2:0]  write_sections,
  output logic [31:0] new_word
);

  logic [31:0] mask;

  always_comb begin
    mask     = lane_mask(write_sections);
    new_word = (old_word & ~mask) | (write_value & mask);
  end

endmodule

// File: rtl/mtimer_multi.sv
// rtl/mtimer_multi.sv - RISC-V machine timer with prescaler and NUM_CMP comparators
//
// Ports:
//   clk24           core clock
//   reset_n         asynchronous active-low reset
//   address         byte address from the core ([1:0] ignored)
//   read_enable     core reads address this cycle
//   write_value     lane-shifted write data
//   write_sections  lane enables; any non-zero value inside the window writes
//   read_value      registered read data (0 when not hit)
//   read_hit        registered: read_value belongs to this block
//   timer_irq       per-channel level interrupt, registered (mtime >= cmp[k])
//   irq_any         OR of timer_irq, coincident with it

import mtimer_pkg::*;

module mtimer_multi #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h8000_0000,
  parameter int          NUM_CMP        = 1,
  parameter int          WINDOW_BITS    = 5,
  parameter int          PRESCALE_WIDTH = 8
) (
  input  logic               clk24,
  input  logic               reset_n,
  input  logic [31:0]        address,
  input  logic               read_enable,
  input  logic [31:0]        write_value,
  input  logic [2:0]         write_sections,
  output logic [31:0]        read_value,
  output logic               read_hit,
  output logic [NUM_CMP-1:0] timer_irq,
  output logic               irq_any
);

  // State
  logic [63:0]               mtime_q, mtime_d;
  logic [63:0]               cmp_q [NUM_CMP];
  logic [63:0]               cmp_d [NUM_CMP];
  logic                      enable_q, enable_d;
  logic [PRESCALE_WIDTH-1:0] div_q, div_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [31:0]               shadow_q, shadow_d;
  logic [31:0]               read_value_q, read_value_d;
  logic                      read_hit_q, read_hit_d;
  logic [NUM_CMP-1:0]        timer_irq_q, timer_irq_d;
  logic                      irq_any_q, irq_any_d;

  // Decode
  logic                      hit;
  logic [WINDOW_BITS-1:0]    offset;
  logic [31:0]               off_w;
  logic                      wr_en, rd_en;
  logic                      wr_lo, wr_hi, wr_ctrl;
  logic                      tick;

  logic [31:0]               ctrl_word;
  logic [31:0]               mtime_lo_new, mtime_hi_new, ctrl_new;
  logic [31:0]               cmp_lo_new [NUM_CMP];
  logic [31:0]               cmp_hi_new [NUM_CMP];
  logic [31:0]               rd_word;
  logic                      unused_bits;

  always_comb begin
    hit     = (address[31:WINDOW_BITS+2] == BASE_ADDRESS[31:WINDOW_BITS+2]);
    offset  = address[WINDOW_BITS+1:2];
    off_w   = {{(32-WINDOW_BITS){1'b0}}, offset};
    wr_en   = hit && (write_sections != 3'b000);
    rd_en   = hit && read_enable;
    wr_lo   = wr_en && (off_w == OFF_MTIME_LO);
    wr_hi   = wr_en && (off_w == OFF_MTIME_HI);
    wr_ctrl = wr_en && (off_w == OFF_CTRL);
  end

  always_comb begin
    ctrl_word                                   = 32'h0000_0000;
    ctrl_word[CTRL_ENABLE_BIT]                  = enable_q;
    ctrl_word[CTRL_DIV_LSB +: PRESCALE_WIDTH]   = div_q;
  end

  lane_write32 u_lw_mtime_lo (
    .old_word       (mtime_q[31:0]),
    .write_value    (write_value),
    .write_sections (write_sections),
    .new_word       (mtime_lo_new)
  );

  lane_write32 u_lw_mtime_hi (
    .old_word       (mtime_q[63:32]),
    .write_value    (write_value),
    .write_sections (write_sections),
    .new_word       (mtime_hi_new)
  );

  lane_write32 u_lw_ctrl (
    .old_word       (ctrl_word),
    .write_value    (write_value),
    .write_sections (write_sections),
    .new_word       (ctrl_new)
  );

  for (genvar g = 0; g < NUM_CMP; g++) begin : g_cmp
    lane_write32 u_lw_cmp_lo (
      .old_word       (cmp_q[g][31:0]),
      .write_value    (write_value),
      .write_sections (write_sections),
      .new_word       (cmp_lo_new[g])
    );
    lane_write32 u_lw_cmp_hi (
      .old_word       (cmp_q[g][63:32]),
      .write_value    (write_value),
      .write_sections (write_sections),
      .new_word       (cmp_hi_new[g])
    );
  end

  // Only the enable and div fields of the merged CTRL word are kept.
  assign unused_bits = ^{address[1:0], ctrl_new};

  // Prescaler: counts 0..div and emits one tick per wrap.
  always_comb begin
    tick    = 1'b0;
    presc_d = presc_q;
    if (enable_q) begin
      if (presc_q == div_q) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PRESCALE_WIDTH'(1);
      end
    end else begin
      presc_d = '0;
    end
    if (wr_ctrl) presc_d = '0;
  end

  always_comb begin
    enable_d = enable_q;
    div_d    = div_q;
    if (wr_ctrl) begin
      enable_d = ctrl_new[CTRL_ENABLE_BIT];
      div_d    = ctrl_new[CTRL_DIV_LSB +: PRESCALE_WIDTH];
    end
  end

  // A software write to either half wins over the tick for the whole 64 bits,
  // so a written value is never off by one.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) mtime_d[31:0]  = mtime_lo_new;
      if (wr_hi) mtime_d[63:32] = mtime_hi_new;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CMP; k++) begin
      cmp_d[k] = cmp_q[k];
      if (wr_en && (off_w == 32'(OFF_CMP_BASE + 2 * k)))
        cmp_d[k][31:0] = cmp_lo_new[k];
      if (wr_en && (off_w == 32'(OFF_CMP_BASE + 2 * k + 1)))
        cmp_d[k][63:32] = cmp_hi_new[k];
      timer_irq_d[k] = (mtime_q >= cmp_q[k]);
    end
    irq_any_d = |timer_irq_d;
  end

  // Read mux uses pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rd_word = 32'h0000_0000;
    if (off_w == OFF_MTIME_LO)   rd_word = mtime_q[31:0];
    if (off_w == OFF_MTIME_HI)   rd_word = shadow_q;
    if (off_w == OFF_CTRL)       rd_word = ctrl_word;
    if (off_w == OFF_IRQ_STATUS) rd_word[NUM_CMP-1:0] = timer_irq_q;
    for (int k = 0; k < NUM_CMP; k++) begin
      if (off_w == 32'(OFF_CMP_BASE + 2 * k))     rd_word = cmp_q[k][31:0];
      if (off_w == 32'(OFF_CMP_BASE + 2 * k + 1)) rd_word = cmp_q[k][63:32];
    end
    read_hit_d   = rd_en;
    read_value_d = rd_en ? rd_word : 32'h0000_0000;
    // Reading LO freezes the upper half so a following HI read is coherent.
    shadow_d     = (rd_en && (off_w == OFF_MTIME_LO)) ? mtime_q[63:32] : shadow_q;
  end

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      mtime_q      <= 64'd0;
      for (int k = 0; k < NUM_CMP; k++) cmp_q[k] <= 64'hFFFF_FFFF_FFFF_FFFF;
      enable_q     <= 1'b1;
      div_q        <= '0;
      presc_q      <= '0;
      shadow_q     <= 32'h0000_0000;
      read_value_q <= 32'h0000_0000;
      read_hit_q   <= 1'b0;
      timer_irq_q  <= '0;
      irq_any_q    <= 1'b0;
    end else begin
      mtime_q      <= mtime_d;
      for (int k = 0; k < NUM_CMP; k++) cmp_q[k] <= cmp_d[k];
      enable_q     <= enable_d;
      div_q        <= div_d;
      presc_q      <= presc_d;
      shadow_q     <= shadow_d;
      read_value_q <= read_value_d;
      read_hit_q   <= read_hit_d;
      timer_irq_q  <= timer_irq_d;
      irq_any_q    <= irq_any_d;
    end
  end

  assign read_value = read_value_q;
  assign read_hit   = read_hit_q;
  assign timer_irq  = timer_irq_q;
  assign irq_any    = irq_any_q;

endmodule

// File: tb/tb_mtimer_multi.sv
// tb/tb_mtimer_multi.sv - directed self-checking bench for mtimer_multi

module tb_mtimer_multi;

  localparam logic [31:0] A_LO     = 32'h8000_0000;
  localparam logic [31:0] A_HI     = 32'h8000_0004;
  localparam logic [31:0] A_CTRL   = 32'h8000_0008;
  localparam logic [31:0] A_STATUS = 32'h8000_000C;
  localparam logic [31:0] A_C0LO   = 32'h8000_0010;
  localparam logic [31:0] A_C0HI   = 32'h8000_0014;
  localparam logic [31:0] A_C1LO   = 32'h8000_0018;
  localparam logic [31:0] A_C1HI   = 32'h8000_001C;
  localparam logic [31:0] A_UNMAP  = 32'h8000_007C;

  logic        clk24 = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address = 32'h0;
  logic        read_enable = 1'b0;
  logic [31:0] write_value = 32'h0;
  logic [2:0]  write_sections = 3'b000;
  logic [31:0] read_value;
  logic        read_hit;
  logic [1:0]  timer_irq;
  logic        irq_any;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] d;
  logic        h;

  mtimer_multi #(
    .BASE_ADDRESS   (32'h8000_0000),
    .NUM_CMP        (2),
    .WINDOW_BITS    (5),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk24          (clk24),
    .reset_n        (reset_n),
    .address        (address),
    .read_enable    (read_enable),
    .write_value    (write_value),
    .write_sections (write_sections),
    .read_value     (read_value),
    .read_hit       (read_hit),
    .timer_irq      (timer_irq),
    .irq_any        (irq_any)
  );

  always #5 clk24 = ~clk24;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk24);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v, input logic [2:0] s);
    address        = a;
    write_value    = v;
    write_sections = s;
    @(posedge clk24);
    #1;
    write_sections = 3'b000;
    address        = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd, output logic rh);
    address     = a;
    read_enable = 1'b1;
    @(posedge clk24);
    #1;
    read_enable = 1'b0;
    address     = 32'h0;
    rd          = read_value;
    rh          = read_hit;
  endtask

  initial begin
    // Power-on reset, then run and pulse reset mid-count
    cycles(3);
    reset_n = 1'b1;
    cycles(20);
    bus_read(A_LO, d, h);
    check("pre_reset_hit", h, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_read_hit", read_hit, 0);
    check("rst_read_value", read_value, 0);
    check("rst_irq", timer_irq, 0);
    check("rst_irq_any", irq_any, 0);
    @(posedge clk24);
    #1;
    reset_n = 1'b1;
    cycles(1);
    bus_read(A_LO, d, h);
    check("rst_mtime_lo", d, 32'h0000_0001);
    check("rst_mtime_hit", h, 1);
    bus_read(A_C0LO, d, h);
    check("rst_cmp0_lo", d, 32'hFFFF_FFFF);
    bus_read(A_C1HI, d, h);
    check("rst_cmp1_hi", d, 32'hFFFF_FFFF);
    bus_read(A_CTRL, d, h);
    check("rst_ctrl", d, 32'h0000_0001);
    check("rst_irq_run", timer_irq, 0);

    // Shadow coherence across a LO->HI carry
    bus_write(A_HI, 32'h0, 3'b111);
    bus_write(A_LO, 32'hFFFF_FFFE, 3'b111);
    cycles(1);
    bus_read(A_LO, d, h);
    check("shadow_lo", d, 32'hFFFF_FFFF);
    cycles(1);
    bus_read(A_HI, d, h);
    check("shadow_hi", d, 32'h0);
    bus_read(A_LO, d, h);
    check("shadow_lo2", d, 32'h0000_0002);
    bus_read(A_HI, d, h);
    check("shadow_hi2", d, 32'h0000_0001);

    // Prescaler div=3
    bus_write(A_CTRL, 32'h0000_0301, 3'b111);
    bus_write(A_HI, 32'h0, 3'b111);
    bus_write(A_LO, 32'h0, 3'b111);
    cycles(12);
    bus_read(A_LO, d, h);
    check("presc_mtime", d, 32'h3);
    bus_read(A_CTRL, d, h);
    check("presc_ctrl", d, 32'h0000_0301);
    bus_write(A_CTRL, 32'h0000_0300, 3'b111);
    bus_read(A_LO, d, h);
    check("disable_mtime", d, 32'h4);
    cycles(10);
    bus_read(A_LO, d, h);
    check("disable_hold", d, 32'h4);

    // Interrupt timing
    bus_write(A_CTRL, 32'h0000_0001, 3'b111);
    bus_write(A_C0LO, 32'd100, 3'b111);
    bus_write(A_C0HI, 32'd0, 3'b111);
    bus_write(A_C1LO, 32'd200, 3'b111);
    bus_write(A_C1HI, 32'd0, 3'b111);
    bus_write(A_HI, 32'd0, 3'b111);
    bus_write(A_LO, 32'd90, 3'b111);
    cycles(10);
    check("irq_before_100", timer_irq, 2'b00);
    check("irq_any_before", irq_any, 0);
    cycles(1);
    check("irq_at_100", timer_irq, 2'b01);
    check("irq_any_100", irq_any, 1);
    cycles(99);
    check("irq_before_200", timer_irq, 2'b01);
    cycles(1);
    check("irq_at_200", timer_irq, 2'b11);
    bus_read(A_STATUS, d, h);
    check("status_11", d, 32'h3);
    bus_write(A_C0HI, 32'd1, 3'b111);
    check("irq0_hold", timer_irq, 2'b11);
    cycles(1);
    check("irq0_fall", timer_irq, 2'b10);
    bus_read(A_STATUS, d, h);
    check("status_10", d, 32'h2);

    // Lane writes
    bus_write(A_HI, 32'h0, 3'b111);
    bus_write(A_LO, 32'h1234_5600, 3'b111);
    cycles(1);
    bus_write(A_LO, 32'h0000_00AB, 3'b001);
    bus_read(A_LO, d, h);
    check("lane_mtime_lo", d, 32'h1234_56AB);
    bus_read(A_HI, d, h);
    check("lane_mtime_hi", d, 32'h0);
    bus_write(A_C1LO, 32'h00DD_0000, 3'b100);
    bus_read(A_C1LO, d, h);
    check("lane_cmp1_lo", d, 32'h00DD_00C8);
    bus_read(A_C0HI, d, h);
    check("cmp0_hi", d, 32'h1);

    // Same-cycle read and write returns the pre-write value
    address        = A_C1LO;
    read_enable    = 1'b1;
    write_value    = 32'h0000_0055;
    write_sections = 3'b111;
    @(posedge clk24);
    #1;
    read_enable    = 1'b0;
    write_sections = 3'b000;
    check("rw_old_value", read_value, 32'h00DD_00C8);
    bus_read(A_C1LO, d, h);
    check("rw_new_value", d, 32'h0000_0055);

    // Decode
    bus_read(A_UNMAP, d, h);
    check("unmap_hit", h, 1);
    check("unmap_data", d, 0);
    bus_read(32'h0000_0000, d, h);
    check("miss_hit", h, 0);
    check("miss_data", d, 0);

    // Wrap from all-ones to zero
    bus_write(A_HI, 32'hFFFF_FFFF, 3'b111);
    bus_write(A_LO, 32'hFFFF_FFFF, 3'b111);
    cycles(1);
    check("wrap_irq_high", timer_irq, 2'b11);
    cycles(1);
    check("wrap_irq_low", timer_irq, 2'b00);
    check("wrap_irq_any", irq_any, 0);
    bus_read(A_LO, d, h);
    check("wrap_lo", d, 32'h1);
    bus_read(A_HI, d, h);
    check("wrap_hi", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
